// File: rtl/cipher_pkg.sv
// Shared FSM encoding, round-index width and mode-update rule for cipher_round_ctrl.
package cipher_pkg;

   localparam int ROUND_IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Conflicting encrypt/decrypt requests in the same cycle cancel out.
   function automatic logic mode_next(input logic cur, input logic set_enc, input logic set_dec);
      logic nxt;
      nxt = cur;
      if (set_enc && !set_dec) nxt = 1'b0;
      else if (set_dec && !set_enc) nxt = 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/cipher_round_ctrl_round_counter.sv
// Round counter: clear wins over enable, subkey index reversed for decrypt, terminal on last round.
// Index is combinational from the count register; no backpressure (the caller gates enable).
module round_counter
   import cipher_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   clear,
   input  logic                   enable,
   input  logic                   dir_dec,
   output logic [ROUND_IDX_W-1:0] round_idx,
   output logic                   terminal
);

   localparam logic [ROUND_IDX_W-1:0] LAST = ROUND_IDX_W'(NUM_ROUNDS - 1);

   logic [ROUND_IDX_W-1:0] count;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + ROUND_IDX_W'(1);
      end
   end

   assign round_idx = dir_dec ? (LAST - count) : count;
   assign terminal  = (count == LAST);

endmodule

// File: rtl/cipher_round_ctrl.sv
// Cipher round sequencer: load -> NUM_ROUNDS rounds -> result held until out_ready; out_valid at T+NUM_ROUNDS+1.
// Optional CIPHER_BYPASS_EN adds a bypass input that skips the rounds; blk_ready only while idle with key ready.
module cipher_round_ctrl
   import cipher_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   key_ready,
   input  logic                   set_encrypt,
   input  logic                   set_decrypt,
   input  logic                   blk_valid,
`ifdef CIPHER_BYPASS_EN
   input  logic                   bypass,
`endif
   output logic                   blk_ready,
   output logic                   load_en,
   output logic                   round_en,
   output logic [ROUND_IDX_W-1:0] round_idx,
   output logic                   mode_dec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   err_nokey
);

   state_t                 state;
   logic                   mode_reg;
   logic                   nokey_seen;
   logic                   xfer;
   logic                   nokey;
   logic                   skip_rounds;
   logic                   last_round;
   logic [ROUND_IDX_W-1:0] cnt_idx;

`ifdef CIPHER_BYPASS_EN
   assign skip_rounds = bypass;
`else
   assign skip_rounds = 1'b0;
`endif

   assign blk_ready = (state == ST_IDLE) && key_ready;
   assign xfer      = blk_valid && blk_ready;
   // A block offered while reset is held must not appear to be loaded.
   assign load_en   = xfer && n_reset;
   assign round_en  = (state == ST_ROUND);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign round_idx = round_en ? cnt_idx : '0;
   assign nokey     = (state == ST_IDLE) && blk_valid && !key_ready;

   round_counter #(
      .NUM_ROUNDS (NUM_ROUNDS)
   ) u_round_counter (
      .clk       (clk),
      .n_reset   (n_reset),
      .clear     (xfer),
      .enable    (round_en),
      .dir_dec   (mode_dec),
      .round_idx (cnt_idx),
      .terminal  (last_round)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= ST_IDLE;
         mode_reg   <= 1'b0;
         mode_dec   <= 1'b0;
         err_nokey  <= 1'b0;
         nokey_seen <= 1'b0;
      end else begin
         // Pulse only on the first cycle of an unserviceable offer.
         err_nokey  <= nokey && !nokey_seen;
         nokey_seen <= nokey;
         mode_reg   <= mode_next(mode_reg, set_encrypt, set_decrypt);
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  mode_dec <= mode_reg;
                  state    <= skip_rounds ? ST_DONE : ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (last_round) state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Bench for cipher_round_ctrl: timing-offset reference model plus directed vectors (16-round and 2-round instances).
module tb_cipher_round_ctrl;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       key_ready, set_encrypt, set_decrypt, blk_valid, out_ready;
   logic       blk_ready, load_en, round_en, mode_dec, out_valid, busy, err_nokey;
   logic [3:0] round_idx;
`ifdef CIPHER_BYPASS_EN
   logic       bypass;
   logic       bypass2;
`endif

   logic       key_ready2, blk_valid2, out_ready2;
   logic       blk_ready2, load_en2, round_en2, mode_dec2, out_valid2, busy2, err_nokey2;
   logic [3:0] round_idx2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cipher_round_ctrl #(.NUM_ROUNDS(N)) dut (
      .clk(clk), .n_reset(n_reset), .key_ready(key_ready),
      .set_encrypt(set_encrypt), .set_decrypt(set_decrypt), .blk_valid(blk_valid),
`ifdef CIPHER_BYPASS_EN
      .bypass(bypass),
`endif
      .blk_ready(blk_ready), .load_en(load_en), .round_en(round_en), .round_idx(round_idx),
      .mode_dec(mode_dec), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err_nokey(err_nokey)
   );

   cipher_round_ctrl #(.NUM_ROUNDS(2)) dut2 (
      .clk(clk), .n_reset(n_reset), .key_ready(key_ready2),
      .set_encrypt(1'b0), .set_decrypt(1'b0), .blk_valid(blk_valid2),
`ifdef CIPHER_BYPASS_EN
      .bypass(bypass2),
`endif
      .blk_ready(blk_ready2), .load_en(load_en2), .round_en(round_en2), .round_idx(round_idx2),
      .mode_dec(mode_dec2), .out_valid(out_valid2), .out_ready(out_ready2),
      .busy(busy2), .err_nokey(err_nokey2)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   // Reference model: a block loaded in cycle T rounds during T+1..T+N, then waits in DONE.
   initial begin : model
      int  cyc, t_xfer, off, e_idx;
      bit  m_active, m_byp, m_mode, m_dec, m_nk_prev, m_err, nk;
      bit  e_round, e_done, e_rdy, e_load;
      cyc = 0; t_xfer = 0;
      m_active = 0; m_byp = 0; m_mode = 0; m_dec = 0; m_nk_prev = 0; m_err = 0;
      forever begin
         @(negedge clk);
         if (!n_reset) begin
            m_active = 0; m_mode = 0; m_dec = 0; m_err = 0; m_nk_prev = 0;
         end
         off     = cyc - t_xfer;
         e_round = m_active && !m_byp && off >= 1 && off <= N;
         e_done  = m_active && !e_round;
         e_rdy   = !m_active && key_ready;
         e_load  = e_rdy && blk_valid && n_reset;
         e_idx   = e_round ? (m_dec ? N - off : off - 1) : 0;
         chk("m_blk_ready", int'(blk_ready), int'(e_rdy));
         chk("m_load_en",   int'(load_en),   int'(e_load));
         chk("m_round_en",  int'(round_en),  int'(e_round));
         chk("m_round_idx", int'(round_idx), e_idx);
         chk("m_out_valid", int'(out_valid), int'(e_done));
         chk("m_busy",      int'(busy),      int'(m_active));
         chk("m_mode_dec",  int'(mode_dec),  int'(m_dec));
         chk("m_err_nokey", int'(err_nokey), int'(m_err));
         if (n_reset) begin
            nk        = !m_active && blk_valid && !key_ready;
            m_err     = nk && !m_nk_prev;
            m_nk_prev = nk;
            if (e_load) begin
               m_active = 1; t_xfer = cyc; m_dec = m_mode;
`ifdef CIPHER_BYPASS_EN
               m_byp = bypass;
`else
               m_byp = 0;
`endif
            end else if (e_done && out_ready) begin
               m_active = 0;
            end
            if (set_encrypt && !set_decrypt) m_mode = 0;
            else if (set_decrypt && !set_encrypt) m_mode = 1;
         end
         cyc++;
      end
   end

   initial begin : stim
      int errs, n, cnt2, first2;
      bit held;
      n_reset = 0; key_ready = 1; set_encrypt = 0; set_decrypt = 0;
      blk_valid = 1; out_ready = 1;
      key_ready2 = 1; blk_valid2 = 0; out_ready2 = 1;
`ifdef CIPHER_BYPASS_EN
      bypass = 0; bypass2 = 0;
`endif
      #2;
      chk("rst_blk_ready_hi", int'(blk_ready), 1);
      chk("rst_load_en",      int'(load_en), 0);
      chk("rst_busy",         int'(busy), 0);
      chk("rst_out_valid",    int'(out_valid), 0);
      key_ready = 0;
      #1;
      chk("rst_blk_ready_lo", int'(blk_ready), 0);
      blk_valid = 0; key_ready = 1;
      repeat (3) tick();
      n_reset = 1;
      tick();

      // Encrypt block, indices 0..15, out_valid at T+17, idle at T+18
      blk_valid = 1; #1;
      chk("enc_load_en", int'(load_en), 1);
      tick(); blk_valid = 0; #1;
      chk("enc_first_idx", int'(round_idx), 0);
      chk("enc_mode", int'(mode_dec), 0);
      repeat (15) tick();
      chk("enc_last_idx", int'(round_idx), 15);
      chk("enc_last_round_en", int'(round_en), 1);
      tick();
      chk("enc_out_valid_t17", int'(out_valid), 1);
      chk("enc_no_round_t17", int'(round_en), 0);
      tick();
      chk("enc_idle_t18", int'(busy), 0);

      // Decrypt block, indices 15 down to 0
      set_decrypt = 1; tick(); set_decrypt = 0;
      blk_valid = 1; tick(); blk_valid = 0; #1;
      chk("dec_first_idx", int'(round_idx), 15);
      chk("dec_mode_first", int'(mode_dec), 1);
      repeat (15) tick();
      chk("dec_last_idx", int'(round_idx), 0);
      chk("dec_mode_last", int'(mode_dec), 1);
      tick();
      chk("dec_out_valid", int'(out_valid), 1);
      tick();

      // Offer without key: one err pulse, then transfer once the key arrives
      key_ready = 0; blk_valid = 1; errs = 0; held = 1;
      repeat (6) begin
         tick();
         errs += int'(err_nokey);
         held &= !blk_ready;
      end
      chk("nokey_single_pulse", errs, 1);
      chk("nokey_blk_ready_lo", int'(held), 1);
      key_ready = 1; #1;
      chk("nokey_then_load", int'(load_en), 1);
      tick(); blk_valid = 0; out_ready = 0;
      key_ready = 0; #1;
      chk("key_drop_no_abort", int'(round_en), 1);
      key_ready = 1;

      // Output backpressure: result held for 10 cycles
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      chk("bp_reach_done", int'(out_valid), 1);
      held = 1;
      repeat (10) begin tick(); held &= out_valid && !blk_ready; end
      chk("bp_held", int'(held), 1);
      out_ready = 1; tick();
      chk("bp_release_idle", int'(busy), 0);

      // Mode change mid-block affects only the next block
      set_encrypt = 1; tick(); set_encrypt = 0;
      blk_valid = 1; tick(); blk_valid = 0;
      repeat (3) tick();
      set_decrypt = 1; tick(); set_decrypt = 0; #1;
      chk("inflight_mode_kept", int'(mode_dec), 0);
      wait_idle("inflight_idle");
      blk_valid = 1; tick(); blk_valid = 0; #1;
      chk("next_block_dec", int'(mode_dec), 1);
      chk("next_block_idx", int'(round_idx), 15);
      wait_idle("next_idle");
      set_encrypt = 1; set_decrypt = 1; tick(); set_encrypt = 0; set_decrypt = 0;
      blk_valid = 1; tick(); blk_valid = 0; #1;
      chk("both_pulses_unchanged", int'(mode_dec), 1);
      wait_idle("both_idle");

      // Reset at round 7
      set_decrypt = 1; tick(); set_decrypt = 0;
      blk_valid = 1; tick(); blk_valid = 0;
      repeat (7) tick();
      chk("pre_rst_idx", int'(round_idx), 8);
      n_reset = 0; #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_round_en", int'(round_en), 0);
      chk("mid_rst_idx", int'(round_idx), 0);
      chk("mid_rst_mode", int'(mode_dec), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      tick(); n_reset = 1; tick();
      chk("post_rst_out_valid", int'(out_valid), 0);
      chk("post_rst_busy", int'(busy), 0);

      // Two-round instance: exactly 2 round cycles, out_valid at T+3
      blk_valid2 = 1; tick(); blk_valid2 = 0;
      cnt2 = 0; first2 = 0;
      for (int i = 1; i <= 5; i++) begin
         cnt2 += int'(round_en2);
         if (out_valid2 && first2 == 0) first2 = i;
         if (i == 2) chk("n2_idx_second", int'(round_idx2), 1);
         tick();
      end
      chk("n2_round_count", cnt2, 2);
      chk("n2_out_valid_t3", first2, 3);

`ifdef CIPHER_BYPASS_EN
      bypass = 1; blk_valid = 1; tick(); blk_valid = 0; bypass = 0; #1;
      chk("byp_out_valid_t1", int'(out_valid), 1);
      chk("byp_no_round", int'(round_en), 0);
      wait_idle("byp_idle");
`endif

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/cipher_round_ctrl.md
CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 16, number of cipher rounds per block (legal 2..16).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock; reset n_reset, asynchronous, active-low.
- n_reset  in  1  asynchronous active-low reset.
- key_ready  in  1  key schedule complete.
- set_encrypt  in  1  one-cycle pulse requesting encrypt mode.
- set_decrypt  in  1  one-cycle pulse requesting decrypt mode.
- blk_valid  in  1  input block available.
- blk_ready  out  1  controller accepts input block.
- load_en  out  1  datapath loads input block.
- round_en  out  1  datapath performs one round.
- round_idx  out  4  subkey index for current round.
- mode_dec  out  1  active block mode: 1 = decrypt, 0 = encrypt.
- out_valid  out  1  result block valid.
- out_ready  in  1  transmit side accepts result.
- busy  out  1  block in flight (state != IDLE).
- err_nokey  out  1  one-cycle pulse: block offered before key ready.

Function
REQ-003 SHALL implement states IDLE, ROUND, DONE; encoding shared via package.
REQ-004 IDLE: blk_ready = key_ready; transfer when blk_valid && blk_ready.
REQ-005 On transfer, load_en = 1 same cycle, round counter cleared, mode_dec latched from mode register, next state ROUND.
REQ-006 ROUND: round_en = 1 every cycle; round_idx = counter (encrypt) or NUM_ROUNDS-1-counter (decrypt); counter increments.
REQ-007 ROUND -> DONE in the cycle counter == NUM_ROUNDS-1; exactly NUM_ROUNDS round_en cycles per block.
REQ-008 DONE: out_valid = 1, held until out_ready; out_valid && out_ready -> IDLE next cycle.
REQ-009 Latency: transfer at cycle T -> round_en T+1..T+NUM_ROUNDS -> out_valid first at T+NUM_ROUNDS+1.
REQ-010 blk_ready, load_en, round_en SHALL be 0 outside their states; round_idx = 0 outside ROUND.
REQ-011 Mode register: set_encrypt -> 0, set_decrypt -> 1; both in same cycle -> unchanged.
REQ-012 Mode pulses in any state SHALL update the mode register, affecting only subsequently loaded blocks; in-flight mode_dec unchanged.
REQ-013 err_nokey SHALL pulse one cycle after the first cycle of blk_valid && !key_ready in IDLE; no further pulse until blk_valid deasserts or key_ready asserts.
REQ-014 key_ready deasserting mid-block SHALL NOT abort; block completes.
REQ-015 busy = (state != IDLE), combinational from state.

Reset
REQ-016 n_reset low SHALL force state IDLE, counter 0, mode register 0, mode_dec 0, err_nokey 0.
REQ-017 Reset mid-block SHALL discard block; out_valid 0 without completing handshake.
REQ-018 All outputs SHALL be 0 while in reset except blk_ready, which follows key_ready.

Configuration
REQ-019 Macro CIPHER_BYPASS_EN: when defined, adds input port bypass (1 bit); a transfer with bypass = 1 goes directly to DONE with no round_en cycles (out_valid at T+1).
REQ-020 Without CIPHER_BYPASS_EN: no bypass port; every block takes NUM_ROUNDS rounds.

Structure
REQ-021 State enum and ROUND_IDX_W = 4 SHALL live in shared package cipher_pkg.
REQ-022 Sub-module round_counter (clear, enable, direction, terminal-count output) SHALL generate counter and round_idx.

Verification
REQ-023 key_ready=1, encrypt, blk_valid pulse at T, out_ready=1 -> round_idx 0..15 at T+1..T+16, out_valid at T+17, IDLE at T+18.
REQ-024 set_decrypt, then block -> round_idx 15 down to 0; mode_dec = 1 throughout.
REQ-025 key_ready=0, blk_valid held 5 cycles -> blk_ready 0, single err_nokey pulse; key_ready=1 -> transfer next cycle.
REQ-026 out_ready=0 for 10 cycles in DONE -> out_valid held, blk_ready 0; out_ready=1 -> IDLE.
REQ-027 set_decrypt during ROUND of encrypt block -> that block stays encrypt, next block decrypt; simultaneous set_encrypt+set_decrypt -> mode unchanged.
REQ-028 n_reset at round 7 -> IDLE, outputs cleared; NUM_ROUNDS=2 -> exactly 2 round_en cycles; with CIPHER_BYPASS_EN, bypass=1 -> out_valid at T+1.
